// File: rtl/peripheral_pkg.sv
// Shared definitions for the simple read/write bus peripherals: register offsets,
// register decode and the bus response convention.
package peripheral_pkg;

    localparam logic [7:0] LED_OUT_OFS    = 8'h00;
    localparam logic [7:0] LED_MODE_OFS   = 8'h04;
    localparam logic [7:0] LED_PERIOD_OFS = 8'h08;
    localparam logic [7:0] LED_STATUS_OFS = 8'h0C;
    localparam logic [7:0] LED_DUTY_BASE  = 8'h40;

    typedef enum logic [2:0] {
        RegNone,
        RegOut,
        RegMode,
        RegPeriod,
        RegStatus,
        RegDuty
    } led_reg_e;

    // A peripheral acknowledges every strobe in the same cycle.
    function automatic logic bus_response(input logic rd, input logic wr);
        return rd | wr;
    endfunction

    function automatic led_reg_e led_decode(input logic [7:0] ofs, input int unsigned num_leds);
        led_reg_e sel;
        sel = RegNone;
        case (ofs)
            LED_OUT_OFS:    sel = RegOut;
            LED_MODE_OFS:   sel = RegMode;
            LED_PERIOD_OFS: sel = RegPeriod;
            LED_STATUS_OFS: sel = RegStatus;
            default: begin
                if (ofs >= LED_DUTY_BASE && ofs[1:0] == 2'b00 &&
                    ((32'(ofs) - 32'(LED_DUTY_BASE)) >> 2) < num_leds) begin
                    sel = RegDuty;
                end
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_pwm_cmp.sv
// Per-channel PWM comparator: on while the shared counter is below the duty value,
// with an all-ones duty forcing the channel permanently on.
module led_pwm_cmp #(
    parameter int unsigned DUTY_W = 8
) (
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_on
);

    assign pwm_on = (&duty) | (pwm_cnt < duty);

endmodule

// File: rtl/led_bank.sv
// Memory-mapped bank of NUM_LEDS LED channels with static, blink and PWM control.
// Define LED_BANK_PWM_EN to build the per-channel DUTY registers and PWM counter.
module led_bank
    import peripheral_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned BLINK_W    = 24,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                response,
    output logic [NUM_LEDS-1:0] leds
);

    led_reg_e            reg_sel;
    logic [5:0]          duty_idx;
    logic                wr_out, wr_mode, wr_period;
    logic [NUM_LEDS-1:0] out_q, mode_q, pwm_on, on, leds_q;
    logic [BLINK_W-1:0]  period_q, blink_cnt_q;
    logic                phase_q;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic                unused;

    assign reg_sel   = led_decode(address[7:0], NUM_LEDS);
    assign duty_idx  = address[7:2] - 6'd16;
    assign wr_out    = write && (reg_sel == RegOut);
    assign wr_mode   = write && (reg_sel == RegMode);
    assign wr_period = write && (reg_sel == RegPeriod);
    assign response  = bus_response(read, write);
    assign unused    = ^{address[31:8], write_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            mode_q   <= '0;
            period_q <= '0;
        end else begin
            if (wr_out)    out_q    <= write_data[NUM_LEDS-1:0];
            if (wr_mode)   mode_q   <= write_data[NUM_LEDS-1:0];
            if (wr_period) period_q <= write_data[BLINK_W-1:0];
        end
    end

    // A PERIOD write restarts the blink cycle in the on phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (wr_period || period_q == '0) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_cnt_q == period_q - BLINK_W'(1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

`ifdef LED_BANK_PWM_EN
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic [DUTY_W-1:0] duty_q [NUM_LEDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '1;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
            if (write && reg_sel == RegDuty) begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (duty_idx == 6'(i)) duty_q[i] <= write_data[DUTY_W-1:0];
                end
            end
        end
    end

    assign pwm_cnt = pwm_cnt_q;
`else
    assign pwm_cnt = '0;
`endif

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        // Without PWM the duty input is constant all-ones, so pwm_on folds to 1.
        led_pwm_cmp #(
            .DUTY_W (DUTY_W)
        ) u_cmp (
            .pwm_cnt (pwm_cnt),
`ifdef LED_BANK_PWM_EN
            .duty    (duty_q[g]),
`else
            .duty    ({DUTY_W{1'b1}}),
`endif
            .pwm_on  (pwm_on[g])
        );
    end

    assign on = out_q & (~mode_q | {NUM_LEDS{phase_q}}) & pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q <= {NUM_LEDS{ACTIVE_LOW}};
        end else begin
            leds_q <= on ^ {NUM_LEDS{ACTIVE_LOW}};
        end
    end

    assign leds = leds_q;

    always_comb begin
        read_data = '0;
        if (read) begin
            case (reg_sel)
                RegOut:    read_data[NUM_LEDS-1:0] = out_q;
                RegMode:   read_data[NUM_LEDS-1:0] = mode_q;
                RegPeriod: read_data[BLINK_W-1:0]  = period_q;
                RegStatus: read_data[0]            = phase_q;
                RegDuty: begin
`ifdef LED_BANK_PWM_EN
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (duty_idx == 6'(i)) read_data[DUTY_W-1:0] = duty_q[i];
                    end
`endif
                end
                default:   read_data = '0;
            endcase
        end
    end

endmodule
